// File: rtl/cpu_pkg.sv
// cpu_pkg: shared data-path widths and arbiter state/owner types
package cpu_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 5;
  typedef enum logic [1:0] {ARB_IDLE, ARB_GNT_CPU, ARB_GNT_HOST} arb_state_e;
  typedef enum logic {OWN_CPU, OWN_HOST} arb_owner_e;
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: two-way round-robin pick; on a tie the requester that did not win last time goes
module rr_pick2
  import cpu_pkg::*;
(
  input  logic       i_cpu_el,
  input  logic       i_host_el,
  input  arb_owner_e i_last,
  output logic       o_valid,
  output arb_owner_e o_pick
);
  logic w_both;
  // pick the lone eligible requester, or alternate against the last winner on a tie
  always_comb begin
    w_both  = i_cpu_el && i_host_el;
    o_valid = i_cpu_el || i_host_el;
    o_pick  = w_both ? (i_last == OWN_HOST ? OWN_CPU : OWN_HOST) : (i_cpu_el ? OWN_CPU : OWN_HOST);
  end
endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: registered round-robin sharing of the data memory between cpu_core and the host port
module data_mem_arbiter
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              host_lock,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  conflict_cnt
);
  arb_state_e        r_state;
  arb_owner_e        r_last;
  arb_owner_e        r_rown;
  logic              r_we;
  logic              r_rv;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_cpu_el;
  logic              w_host_el;
  logic              w_valid;
  arb_owner_e        w_pick;

  // a requester granted this cycle sits out the next one; host_lock fences the CPU off
  always_comb begin
    w_cpu_el  = cpu_req && !host_lock && r_state != ARB_GNT_CPU;
    w_host_el = host_req && r_state != ARB_GNT_HOST;
  end

  rr_pick2 u_pick (
    .i_cpu_el (w_cpu_el),
    .i_host_el(w_host_el),
    .i_last   (r_last),
    .o_valid  (w_valid),
    .o_pick   (w_pick)
  );

  // grant state, captured request, read tag and saturating conflict counter
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= ARB_IDLE;
      r_last  <= OWN_HOST;
      r_rown  <= OWN_CPU;
      r_we    <= 1'b0;
      r_rv    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= !w_valid ? ARB_IDLE : (w_pick == OWN_CPU ? ARB_GNT_CPU : ARB_GNT_HOST);
      r_rv    <= r_state != ARB_IDLE && !r_we;
      r_rown  <= r_state == ARB_GNT_CPU ? OWN_CPU : OWN_HOST;
      if (w_valid) begin
        r_last  <= w_pick;
        r_we    <= w_pick == OWN_CPU ? cpu_we : host_we;
        r_addr  <= w_pick == OWN_CPU ? cpu_addr : host_addr;
        r_wdata <= w_pick == OWN_CPU ? cpu_wdata : host_wdata;
      end
      if (w_cpu_el && w_host_el && r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // memory strobes follow the grant state; read data is shared, rvalid picks the owner
  always_comb begin
    cpu_gnt      = r_state == ARB_GNT_CPU;
    host_gnt     = r_state == ARB_GNT_HOST;
    mem_en       = r_state != ARB_IDLE;
    mem_we       = mem_en && r_we;
    mem_addr     = r_addr;
    mem_wdata    = r_wdata;
    cpu_rvalid   = r_rv && r_rown == OWN_CPU;
    host_rvalid  = r_rv && r_rown == OWN_HOST;
    cpu_rdata    = mem_rdata;
    host_rdata   = mem_rdata;
    conflict_cnt = r_cnt;
  end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed and random checks of data_mem_arbiter against a cycle-level reference model
module tb_data_mem_arbiter;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, host_req = 1'b0, host_we = 1'b0, host_lock = 1'b0;
  logic [4:0]  cpu_addr = '0, host_addr = '0;
  logic [15:0] cpu_wdata = '0, host_wdata = '0;
  logic        cpu_gnt, cpu_rvalid, host_gnt, host_rvalid, mem_en, mem_we;
  logic [15:0] cpu_rdata, host_rdata, mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic [4:0]  mem_addr;
  logic [7:0]  conflict_cnt;

  logic [15:0] mac_mem [32] = '{default: 16'h0};
  logic [15:0] ref_mem [32] = '{default: 16'h0};

  int checks = 0;
  int failures = 0;
  int m_prev = 0;
  int m_last = 2;
  int m_cnt = 0;
  int m_rown = 0;
  logic m_pend = 1'b0;
  logic [15:0] m_rdat = '0;
  logic [4:0] m_addr = '0;
  logic [15:0] m_wdata = '0;
  int nc, nh;

  data_mem_arbiter #(.DATA_W(16), .ADDR_W(5), .CNT_W(8)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_lock(host_lock), .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
  );

  always #5 clock = ~clock;

  // single-port 32x16 memory macro with one-cycle read latency
  always @(posedge clock) begin
    if (mem_en && mem_we) mac_mem[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= mac_mem[mem_addr];
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock of the reference: decide the grant from current inputs, advance, compare
  task automatic step();
    int ce, he, win, rown;
    logic exp_we, rpend;
    logic [15:0] rdat;
    if (!reset) begin
      @(posedge clock); #1;
      m_prev = 0; m_last = 2; m_cnt = 0; m_pend = 1'b0; m_addr = '0; m_wdata = '0;
      chk("rst_cpu_gnt", cpu_gnt, 0);
      chk("rst_host_gnt", host_gnt, 0);
      chk("rst_cpu_rvalid", cpu_rvalid, 0);
      chk("rst_host_rvalid", host_rvalid, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_conflict_cnt", conflict_cnt, 0);
      return;
    end
    ce = (cpu_req && !host_lock && m_prev != 1) ? 1 : 0;
    he = (host_req && m_prev != 2) ? 1 : 0;
    win = (ce && he) ? (m_last == 1 ? 2 : 1) : ce ? 1 : he ? 2 : 0;
    if (ce && he && m_cnt < 255) m_cnt++;
    rpend = m_pend; rown = m_rown; rdat = m_rdat;
    m_pend = 1'b0;
    exp_we = 1'b0;
    if (win == 1) begin exp_we = cpu_we; m_addr = cpu_addr; m_wdata = cpu_wdata; end
    if (win == 2) begin exp_we = host_we; m_addr = host_addr; m_wdata = host_wdata; end
    if (win != 0) begin
      if (exp_we) ref_mem[m_addr] = m_wdata;
      else begin m_pend = 1'b1; m_rown = win; m_rdat = ref_mem[m_addr]; end
      m_last = win;
    end
    m_prev = win;
    @(posedge clock); #1;
    chk("cpu_gnt", cpu_gnt, win == 1);
    chk("host_gnt", host_gnt, win == 2);
    chk("mem_en", mem_en, win != 0);
    chk("mem_we", mem_we, exp_we);
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_wdata", mem_wdata, m_wdata);
    chk("cpu_rvalid", cpu_rvalid, rpend && rown == 1);
    chk("host_rvalid", host_rvalid, rpend && rown == 2);
    chk("conflict_cnt", conflict_cnt, m_cnt);
    if (rpend && rown == 1) chk("cpu_rdata", cpu_rdata, rdat);
    if (rpend && rown == 2) chk("host_rdata", host_rdata, rdat);
    if (win == 1) nc++;
    if (win == 2) nh++;
  endtask

  initial begin
    cpu_req = 1'b1; host_req = 1'b1;
    step(); step();
    reset = 1'b1;
    step();
    chk("first_gnt_is_cpu", cpu_gnt, 1);
    cpu_req = 1'b0; host_req = 1'b0;
    step(); step();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5'd3; cpu_wdata = 16'h0008;
    step();
    chk("store_gnt", cpu_gnt, 1);
    chk("store_we", mem_we, 1);
    cpu_req = 1'b0;
    step();
    cpu_req = 1'b1; cpu_we = 1'b0;
    step();
    chk("load_gnt", cpu_gnt, 1);
    chk("load_we", mem_we, 0);
    cpu_req = 1'b0;
    step();
    chk("load_rvalid", cpu_rvalid, 1);
    chk("load_rdata", cpu_rdata, 16'h0008);
    chk("load_host_rvalid", host_rvalid, 0);
    cpu_req = 1'b1; host_req = 1'b1; host_we = 1'b1; host_addr = 5'd9; host_wdata = 16'hbeef;
    repeat (6) begin
      cpu_addr = 5'($urandom_range(0, 31)); host_addr = 5'($urandom_range(0, 31));
      step();
    end
    host_lock = 1'b1; nc = 0; nh = 0;
    repeat (10) step();
    chk("lock_no_cpu_gnt", nc, 0);
    chk("lock_host_gnts", nh, 5);
    host_lock = 1'b0; nc = 0;
    repeat (2) step();
    chk("unlock_cpu_gnt", nc > 0, 1);
    repeat (600) begin
      if (!cpu_req || m_prev == 1) begin
        cpu_req = 1'($urandom_range(0, 1)); cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = 5'($urandom_range(0, 31)); cpu_wdata = 16'($urandom());
      end
      if (!host_req || m_prev == 2) begin
        host_req = 1'($urandom_range(0, 1)); host_we = 1'($urandom_range(0, 1));
        host_addr = 5'($urandom_range(0, 31)); host_wdata = 16'($urandom());
      end
      host_lock = $urandom_range(0, 3) == 0;
      step();
    end
    host_lock = 1'b0;
    repeat (300) begin
      cpu_req = 1'b1; host_req = 1'b1;
      cpu_we = 1'($urandom_range(0, 1)); host_we = 1'($urandom_range(0, 1));
      step();
      cpu_req = 1'b0; host_req = 1'b0;
      step();
    end
    chk("cnt_saturated", conflict_cnt, 255);
    step();
    host_req = 1'b1; host_we = 1'b0; host_addr = 5'd7;
    step();
    chk("mid_read_host_gnt", host_gnt, 1);
    host_req = 1'b0; reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    chk("post_reset_host_rvalid", host_rvalid, 0);
    chk("post_reset_idle", mem_en, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
